rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//  Parametrised N-channel, W-bit streaming multiplexer; successor of the 4:1 select mux.
//  Chooses one valid input per cycle using round-robin, fixed-priority, or external-select mode.
//  Uses valid/ready handshakes and has one registered output stage.
//  Sits between several producer streams and one shared consumer (bus/FIFO port).
// PARAMETERS
//  NCH   4  number of input channels, >=1
//  DW    8  data width per channel, bits
//  MODE  0  0 = round-robin, 1 = fixed priority (lowest index wins), 2 = external select via sel
//  CW    derived = (NCH>1) ? $clog2(NCH) : 1; not user-set
// PORTS
//  clk        in   1       single clock; everything updates on the rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   NCH     per-channel valid
//  in_data    in   NCH*DW  channel i occupies bits [i*DW +: DW]
//  in_ready   out  NCH     per-channel ready; combinational; one-hot or zero
//  sel        in   CW      channel select; read only when MODE==2
//  out_valid  out  1       registered
//  out_data   out  DW      registered
//  out_ch     out  CW      registered index of the channel that supplied out_data
//  out_ready  in   1       consumer ready
// BEHAVIOUR
//  Reset values
//   - out_valid = 0, out_data = 0, out_ch = 0, rr pointer ptr = 0.
//   - in_ready = 0 in every cycle where rst = 1.
//  Load and grant
//   - load = ~out_valid | out_ready.
//   - g = winning channel; grant exists only when load = 1 and the winner is valid.
//   - in_ready[g] = 1 only when a grant exists; all other bits = 0.
//   - A transfer on channel g is in_valid[g] & in_ready[g].
//  Output register, on each edge when load = 1:
//   - Grant exists: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
//   - No grant: out_valid <= 0; out_data and out_ch hold.
//   - When load = 0, all outputs hold (output stall).
//  Latency and throughput
//   - Latency is 1 cycle from input transfer to out_valid.
//   - Throughput is 1 word per cycle when out_ready is held high.
//  Arbitration
//   - MODE 0: search starts at ptr and moves upward, wrapping NCH-1 -> 0. The first valid channel wins.
//     After a grant, ptr <= (g+1) mod NCH. ptr changes only on a grant.
//   - MODE 1: lowest-index valid channel wins. ptr stays 0.
//   - MODE 2: g = sel. A grant exists only if in_valid[sel] = 1; otherwise there is no grant and no
//     fallback. If sel >= NCH, there is no grant.
//  Boundaries
//   - NCH = 1: always channel 0 (behaves as a 1-deep register slice).
//   - All in_valid = 0: out_valid drains to 0 after the pending word is accepted.
//   - out_ready = 0 while out_valid = 1: every in_ready = 0, and data/ch are stable until accepted.
//   - Simultaneous accept-and-load: a new word replaces the old one with no bubble.
//   - Reset mid-transfer: the pending output word is discarded and ptr returns to 0.
//  Input contract and sizing
//   - Inputs must hold data while valid and not yet ready; the block does not check this.
//   - Widths: out_ch is CW bits. ptr is CW bits with explicit mod-NCH wrap (NCH may be a non-power-of-2).
// STRUCTURE
//  Package arb_mux_pkg:
//   - MODE_RR = 0, MODE_FIXED = 1, MODE_SEL = 2
//   - function clog2_min1(n)
//  Sub-module rr_pick #(NCH):
//   - inputs: req[NCH], ptr[CW]
//   - outputs: gnt_idx[CW], gnt_any
//   - purely combinational rotate, priority-encode, un-rotate.
//   - used by MODE 0 and 1 (MODE 1 ties ptr = 0).
//  Top module: handshake logic, output register, ptr register.
// TESTING
//  1. Reset, NCH=4 DW=8 MODE=0: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0,
//     out_data=0x00, out_ch=0.
//  2. RR fairness: all in_valid=1, data i = 0xA0+i, out_ready=1 -> out_ch sequence 0,1,2,3,0,... and
//     out_data 0xA0..0xA3; each in_ready pulses once per 4 cycles.
//  3. Back-pressure: out_ready=0 for 5 cycles while out_valid=1 -> out_data/out_ch frozen, in_ready=0;
//     on release, the next channel follows with no bubble.
//  4. Wrap and skip: ptr=3, only in_valid[1]=1 -> grant ch1, then ptr=2; NCH=3 build wraps 2->0.
//  5. MODE=1: in_valid=4'b1010 -> ch1 wins every cycle; ch3 starves.
//     MODE=2: sel=2 with in_valid[2]=0 -> no grant, out_valid=0.
//  6. Reset mid-stream: assert rst while out_valid=1, out_ch=2 -> next cycle out_valid=0;
//     after release, the first grant is ch0.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the streaming arbiter mux.
// Mode encodings and select-width sizing.
package arb_mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;
  localparam int MODE_SEL   = 2;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Producer-side and consumer-side stream bundle for rr_arb_mux.
// The slave modport faces the arbiter.
interface rr_arb_mux_if
  import arb_mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int CW  = clog2_min1(NCH)
);

  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic [CW-1:0]     sel;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic              out_ready;

  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/rr_arb_mux_rr_pick.sv
// Rotating priority picker: first request at or above ptr,
// wrapping modulo NCH. Purely combinational.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = clog2_min1(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_any
);

  int            j;
  logic [CW-1:0] k;

  // Walk from farthest to nearest so the nearest request wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    k       = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NCH) j = j - NCH;
      k = CW'(j);
      if (req[k]) begin
        gnt_any = 1'b1;
        gnt_idx = k;
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready stream mux with round-robin, fixed
// or external select arbitration and one registered output.
module rr_arb_mux
  import arb_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int DW   = 8,
  parameter int MODE = MODE_RR
) (
  input  logic        clk,
  input  logic        rst,
  rr_arb_mux_if.slave bus
);

  localparam int CW = clog2_min1(NCH);

  logic [CW-1:0]  ptr_q;
  logic [CW-1:0]  pick_ptr;
  logic [CW-1:0]  pick_idx;
  logic           pick_any;
  logic [CW-1:0]  win;
  logic           win_ok;
  logic           load;
  logic           gnt;
  logic [DW-1:0]  win_data;
  logic [NCH-1:0] in_ready_c;
  logic           out_valid_q;
  logic [DW-1:0]  out_data_q;
  logic [CW-1:0]  out_ch_q;

  assign pick_ptr = (MODE == MODE_RR) ? ptr_q : '0;

  rr_pick #(
    .NCH (NCH)
  ) u_pick (
    .req     (bus.in_valid),
    .ptr     (pick_ptr),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // External select never falls back; out-of-range sel matches nothing.
  always_comb begin
    win    = pick_idx;
    win_ok = pick_any;
    if (MODE == MODE_SEL) begin
      win    = bus.sel;
      win_ok = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (bus.sel == CW'(i)) win_ok = bus.in_valid[i];
      end
    end
  end

  assign load = ~out_valid_q | bus.out_ready;
  assign gnt  = load & win_ok & ~rst;

  always_comb begin
    win_data   = '0;
    in_ready_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win == CW'(i)) begin
        win_data      = bus.in_data[i*DW +: DW];
        in_ready_c[i] = gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else if (load) begin
      if (gnt) begin
        out_valid_q <= 1'b1;
        out_data_q  <= win_data;
        out_ch_q    <= win;
        if (MODE == MODE_RR) begin
          ptr_q <= (win == CW'(NCH - 1)) ? '0 : win + 1'b1;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: RR, NCH=3 wrap,
// fixed-priority and external-select builds.
module tb_rr_arb_mux;
  import arb_mux_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rr_arb_mux_if #(.NCH(4), .DW(8)) if0 ();
  rr_arb_mux_if #(.NCH(3), .DW(8)) if3 ();
  rr_arb_mux_if #(.NCH(4), .DW(8)) if1 ();
  rr_arb_mux_if #(.NCH(4), .DW(8)) if2 ();

  rr_arb_mux #(.NCH(4), .DW(8), .MODE(MODE_RR)) u_rr (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  rr_arb_mux #(.NCH(3), .DW(8), .MODE(MODE_RR)) u_rr3 (
    .clk (clk), .rst (rst), .bus (if3.slave)
  );
  rr_arb_mux #(.NCH(4), .DW(8), .MODE(MODE_FIXED)) u_fix (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );
  rr_arb_mux #(.NCH(4), .DW(8), .MODE(MODE_SEL)) u_sel (
    .clk (clk), .rst (rst), .bus (if2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;

    if0.in_valid  = 4'b1111;
    if0.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    if0.sel       = '0;
    if0.out_ready = 1'b1;
    if3.in_valid  = '0;
    if3.in_data   = {8'hB2, 8'hB1, 8'hB0};
    if3.sel       = '0;
    if3.out_ready = 1'b1;
    if1.in_valid  = '0;
    if1.in_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    if1.sel       = '0;
    if1.out_ready = 1'b1;
    if2.in_valid  = '0;
    if2.in_data   = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    if2.sel       = '0;
    if2.out_ready = 1'b1;

    step();
    step();
    check("rst_rdy", 32'(if0.in_ready), 32'h0);
    check("rst_ov", 32'(if0.out_valid), 32'h0);
    check("rst_dat", 32'(if0.out_data), 32'h0);
    check("rst_ch", 32'(if0.out_ch), 32'h0);

    rst = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_rdy", 32'(if0.in_ready), 32'(1 << (k % 4)));
      step();
      check("rr_ov", 32'(if0.out_valid), 32'h1);
      check("rr_ch", 32'(if0.out_ch), 32'(k % 4));
      check("rr_dat", 32'(if0.out_data), 32'(8'hA0 + k % 4));
    end

    if0.out_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_rdy", 32'(if0.in_ready), 32'h0);
      step();
      check("bp_ov", 32'(if0.out_valid), 32'h1);
      check("bp_ch", 32'(if0.out_ch), 32'h3);
      check("bp_dat", 32'(if0.out_data), 32'hA3);
    end
    if0.out_ready = 1'b1;
    #1;
    check("rel_rdy", 32'(if0.in_ready), 32'h1);
    step();
    check("rel_ov", 32'(if0.out_valid), 32'h1);
    check("rel_ch", 32'(if0.out_ch), 32'h0);
    check("rel_dat", 32'(if0.out_data), 32'hA0);

    if0.in_valid = 4'b0100;
    step();
    check("wr_ch2", 32'(if0.out_ch), 32'h2);
    if0.in_valid = 4'b0010;
    #1;
    check("wr_rdy", 32'(if0.in_ready), 32'h2);
    step();
    check("wr_ch1", 32'(if0.out_ch), 32'h1);
    if0.in_valid = 4'b1010;
    step();
    check("wr_ch3", 32'(if0.out_ch), 32'h3);

    if0.in_valid = 4'b0000;
    #1;
    check("dr_rdy", 32'(if0.in_ready), 32'h0);
    step();
    check("dr_ov", 32'(if0.out_valid), 32'h0);
    check("dr_ch", 32'(if0.out_ch), 32'h3);
    check("dr_dat", 32'(if0.out_data), 32'hA3);

    if0.in_valid = 4'b1111;
    step();
    step();
    step();
    check("mid_ov", 32'(if0.out_valid), 32'h1);
    check("mid_ch", 32'(if0.out_ch), 32'h2);
    rst = 1'b1;
    #1;
    check("mid_rdy", 32'(if0.in_ready), 32'h0);
    step();
    check("mid_rst_ov", 32'(if0.out_valid), 32'h0);
    check("mid_rst_ch", 32'(if0.out_ch), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rdy", 32'(if0.in_ready), 32'h1);
    step();
    check("post_ch", 32'(if0.out_ch), 32'h0);
    check("post_dat", 32'(if0.out_data), 32'hA0);

    if3.in_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      check("n3_ch", 32'(if3.out_ch), 32'(k % 3));
      check("n3_dat", 32'(if3.out_data), 32'(8'hB0 + k % 3));
    end

    if1.in_valid = 4'b1010;
    #1;
    check("fx_rdy", 32'(if1.in_ready), 32'h2);
    for (int k = 0; k < 3; k++) begin
      step();
      check("fx_ch", 32'(if1.out_ch), 32'h1);
      check("fx_dat", 32'(if1.out_data), 32'hC1);
      check("fx_rdy_k", 32'(if1.in_ready), 32'h2);
    end

    if2.sel      = 2'd2;
    if2.in_valid = 4'b1011;
    #1;
    check("sl_rdy2", 32'(if2.in_ready), 32'h0);
    step();
    check("sl_ov2", 32'(if2.out_valid), 32'h0);
    if2.sel = 2'd3;
    #1;
    check("sl_rdy3", 32'(if2.in_ready), 32'h8);
    step();
    check("sl_ov3", 32'(if2.out_valid), 32'h1);
    check("sl_ch3", 32'(if2.out_ch), 32'h3);
    check("sl_dat3", 32'(if2.out_data), 32'hD3);
    if2.sel = 2'd2;
    step();
    check("sl_drain", 32'(if2.out_valid), 32'h0);
    check("sl_hold", 32'(if2.out_ch), 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
